m_mask_bank: RTL and testbench

Parametrised, multi-context successor to the MPU mask stage.
- Holds NCTX banks of NCH WORD-wide mask registers (channel 0 interrupt, 1 pull-up/down, 2 control, 3 spare).
- Emits a tagged DWORD instruction for every channel whose effective mask changed, with a valid/ready handshake.
- Supports a clean, handshake-safe context switch between banks; sits between the CPU-side mask-write interface and the downstream m_register consumers.

---
 rtl/m_mask_pkg.sv | 24 ++
 rtl/m_rr_arbiter.sv | 28 ++
 rtl/m_mask_bank.sv | 149 ++++++++++++++
 tb/tb_m_mask_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_mask_pkg.sv
// Shared types and helpers for the multi-context mask bank:
// FSM state encoding, channel indices and the instruction tag builder.
package m_mask_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SWITCH = 2'd2
   } state_t;

   localparam logic [1:0] CH_INT  = 2'd0;
   localparam logic [1:0] CH_PULL = 2'd1;
   localparam logic [1:0] CH_CTRL = 2'd2;

   localparam int TAG_MAX = 64;

   // Tag is the channel number in the top two bits with ones below; callers cast to WORD bits.
   function automatic logic [TAG_MAX-1:0] tag(input logic [1:0] ch, input int word);
      logic [TAG_MAX-1:0] ones;
      ones = (TAG_MAX'(1'b1) << (word - 2)) - TAG_MAX'(1'b1);
      return (TAG_MAX'(ch) << (word - 2)) | ones;
   endfunction

endpackage

// File: rtl/m_rr_arbiter.sv
// Round-robin find-first-set over NCH request lines, starting the search at ptr_i
// and wrapping; any_o flags that at least one request is present.
module m_rr_arbiter #(
   parameter int NCH = 3
) (
   input  logic [NCH-1:0] req_i,
   input  logic [1:0]     ptr_i,
   output logic [1:0]     grant_o,
   output logic           any_o
);

   logic [NCH-1:0] rot_s;
   int             off_s;
   int             sum_s;

   // Rotate so the pointer lands on bit 0, take the lowest set bit, then rotate the index back.
   always_comb begin
      rot_s = NCH'({req_i, req_i} >> ptr_i);
      off_s = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
         off_s = rot_s[i] ? i : off_s;
      end
      sum_s   = int'(ptr_i) + off_s;
      grant_o = 2'((sum_s >= NCH) ? (sum_s - NCH) : sum_s);
      any_o   = |req_i;
   end

endmodule

// File: rtl/m_mask_bank.sv
// Multi-context mask bank: NCTX banks of NCH mask registers, issuing a tagged
// instruction per changed channel of the active bank and switching banks on request.
module m_mask_bank
   import m_mask_pkg::*;
#(
   parameter int WORD  = 8,
   parameter int DWORD = 16,
   parameter int NCH   = 3,
   parameter int NCTX  = 4,
   parameter int CTXW  = $clog2(NCTX)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [CTXW-1:0]  wr_ctx,
   input  logic [1:0]       wr_ch,
   input  logic [WORD-1:0]  wr_data,
   input  logic             ctx_switch,
   input  logic [CTXW-1:0]  ctx_sel,
   input  logic             instr_ready,
   output logic [DWORD-1:0] instruction,
   output logic             instr_valid,
   output logic [CTXW-1:0]  context_o,
   output logic             busy,
   output logic             err
);

   state_t           state_q, state_d;
   logic [WORD-1:0]  mask_q [NCTX][NCH];
   logic [NCH-1:0]   dirty_q, dirty_d, wr_set_s;
   logic [1:0]       rr_q, rr_d, iss_q, iss_d, grant_s;
   logic             any_s;
   logic             pend_q, pend_d;
   logic [CTXW-1:0]  tgt_q, tgt_d, ctx_q, ctx_d;
   logic [DWORD-1:0] instr_q, instr_d;
   logic             valid_q, valid_d, err_q, err_d;
   logic             wr_ok_s, sw_ok_s;
   logic [WORD-1:0]  tag_s;

   assign wr_ok_s  = wr_en && (int'(wr_ctx) < NCTX) && (int'(wr_ch) < NCH);
   assign sw_ok_s  = ctx_switch && (int'(ctx_sel) < NCTX);
   assign err_d    = (wr_en && !wr_ok_s) || (ctx_switch && !sw_ok_s);
   assign wr_set_s = (wr_ok_s && (wr_ctx == ctx_q)) ? (NCH'(1'b1) << wr_ch) : '0;
   assign tag_s    = WORD'(tag(grant_s, WORD));

   m_rr_arbiter #(.NCH(NCH)) u_arb (
      .req_i   (dirty_q),
      .ptr_i   (rr_q),
      .grant_o (grant_s),
      .any_o   (any_s)
   );

   // Mask storage; illegal writes never reach here.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCTX; c++) begin
            for (int h = 0; h < NCH; h++) begin
               mask_q[c][h] <= '0;
            end
         end
      end else if (wr_ok_s) begin
         mask_q[wr_ctx][wr_ch] <= wr_data;
      end
   end

   // Next-state logic; write-set dirty bits are OR-ed in last so they win over an issue clear.
   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
      dirty_d = dirty_q;
      rr_d    = rr_q;
      iss_d   = iss_q;
      pend_d  = pend_q;
      tgt_d   = tgt_q;
      instr_d = instr_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_d = S_SWITCH;
            end else if (any_s) begin
               instr_d          = {tag_s, mask_q[ctx_q][grant_s]};
               dirty_d[grant_s] = 1'b0;
               iss_d            = grant_s;
               valid_d          = 1'b1;
               state_d          = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (instr_ready) begin
               valid_d = 1'b0;
               rr_d    = (iss_q == 2'(NCH - 1)) ? 2'd0 : (iss_q + 2'd1);
               state_d = S_IDLE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_SWITCH: begin
            ctx_d   = tgt_q;
            dirty_d = '1;
            rr_d    = 2'd0;
            pend_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      dirty_d = dirty_d | wr_set_s;
      pend_d  = pend_d | sw_ok_s;
      tgt_d   = sw_ok_s ? ctx_sel : tgt_d;
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ctx_q   <= '0;
         dirty_q <= '0;
         rr_q    <= 2'd0;
         iss_q   <= 2'd0;
         pend_q  <= 1'b0;
         tgt_q   <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctx_q   <= ctx_d;
         dirty_q <= dirty_d;
         rr_q    <= rr_d;
         iss_q   <= iss_d;
         pend_q  <= pend_d;
         tgt_q   <= tgt_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign context_o   = ctx_q;
   assign busy        = pend_q;
   assign err         = err_q;

endmodule

// File: tb/tb_m_mask_bank.sv
// Directed bench for m_mask_bank (NCTX=3 so an out-of-range context is reachable);
// inputs change and outputs are sampled on the falling edge.
module tb_m_mask_bank;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_ctx = 2'd0;
   logic [1:0]  wr_ch = 2'd0;
   logic [7:0]  wr_data = 8'h00;
   logic        ctx_switch = 1'b0;
   logic [1:0]  ctx_sel = 2'd0;
   logic        instr_ready = 1'b0;
   logic [15:0] instruction;
   logic        instr_valid;
   logic [1:0]  context_o;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   m_mask_bank #(.WORD(8), .DWORD(16), .NCH(3), .NCTX(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_ctx      (wr_ctx),
      .wr_ch       (wr_ch),
      .wr_data     (wr_data),
      .ctx_switch  (ctx_switch),
      .ctx_sel     (ctx_sel),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .context_o   (context_o),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic write(input logic [1:0] c, input logic [1:0] h, input logic [7:0] d);
      wr_en = 1'b1; wr_ctx = c; wr_ch = h; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_valid(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({instruction, instr_valid, context_o, busy, err} !== 21'd0) begin
         errors++;
         $display("FAIL reset_state got instr=%h v=%b ctx=%0d busy=%b err=%b want all 0", instruction, instr_valid, context_o, busy, err);
      end
   endtask

   task automatic test_single();
      bit found;
      instr_ready = 1'b0;
      write(2'd0, 2'd1, 8'hA5);
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL single_early got v=%b want 0", instr_valid); end
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 16'h7FA5) begin
         errors++; $display("FAIL single_latency got v=%b instr=%h want 1 7fa5", instr_valid, instruction);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instruction !== 16'h7FA5) begin
            errors++; $display("FAIL single_hold[%0d] got v=%b instr=%h want 1 7fa5", i, instr_valid, instruction);
         end
      end
      instr_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL single_drop got v=%b want 0", instr_valid); end
      wait_valid(found);
      checks++;
      if (found) begin errors++; $display("FAIL single_spurious got instr=%h want no valid", instruction); end
   endtask

   task automatic test_order();
      bit found;
      logic [15:0] exp [3] = '{16'h3F11, 16'h7F22, 16'hBF33};
      instr_ready = 1'b0;
      write(2'd0, 2'd0, 8'h11);
      write(2'd0, 2'd1, 8'h22);
      write(2'd0, 2'd2, 8'h33);
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid(found);
         checks++;
         if (!found || instruction !== exp[k]) begin
            errors++; $display("FAIL order[%0d] got v=%b instr=%h want %h", k, instr_valid, instruction, exp[k]);
         end
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b0) begin errors++; $display("FAIL order_gap[%0d] got v=%b want 0", k, instr_valid); end
      end
   endtask

   task automatic test_switch();
      bit found;
      logic [15:0] exp [3] = '{16'h3F00, 16'h7F00, 16'hBF0F};
      instr_ready = 1'b1;
      write(2'd2, 2'd2, 8'h0F);
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL switch_noissue got v=%b err=%b want 0 0", instr_valid, err);
      end
      ctx_switch = 1'b1; ctx_sel = 2'd2;
      @(negedge clk);
      ctx_switch = 1'b0;
      checks++;
      if (busy !== 1'b1 || context_o !== 2'd0) begin
         errors++; $display("FAIL switch_busy got busy=%b ctx=%0d want 1 0", busy, context_o);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || context_o !== 2'd2) begin
         errors++; $display("FAIL switch_done got busy=%b ctx=%0d want 0 2", busy, context_o);
      end
      for (int k = 0; k < 3; k++) begin
         wait_valid(found);
         checks++;
         if (!found || instruction !== exp[k]) begin
            errors++; $display("FAIL switch_issue[%0d] got v=%b instr=%h want %h", k, instr_valid, instruction, exp[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_stall_switch();
      bit found;
      logic [15:0] exp [3] = '{16'h3F11, 16'h7F22, 16'hBF33};
      instr_ready = 1'b0;
      write(2'd2, 2'd1, 8'h44);
      wait_valid(found);
      checks++;
      if (!found || instruction !== 16'h7F44) begin errors++; $display("FAIL stall_first got instr=%h want 7f44", instruction); end
      write(2'd2, 2'd1, 8'h55);
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 16'h7F44) begin
         errors++; $display("FAIL stall_payload got v=%b instr=%h want 1 7f44", instr_valid, instruction);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      wait_valid(found);
      checks++;
      if (!found || instruction !== 16'h7F55) begin errors++; $display("FAIL stall_reissue got instr=%h want 7f55", instruction); end
      @(negedge clk);
      instr_ready = 1'b0;
      write(2'd2, 2'd0, 8'h66);
      wait_valid(found);
      ctx_switch = 1'b1; ctx_sel = 2'd0;
      @(negedge clk);
      ctx_switch = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instruction !== 16'h3F66 || busy !== 1'b1 || context_o !== 2'd2) begin
            errors++; $display("FAIL stall_hold[%0d] got v=%b instr=%h busy=%b ctx=%0d want 1 3f66 1 2", i, instr_valid, instruction, busy, context_o);
         end
         @(negedge clk);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || context_o !== 2'd2) begin
         errors++; $display("FAIL stall_complete got v=%b ctx=%0d want 0 2", instr_valid, context_o);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (context_o !== 2'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL stall_switched got ctx=%0d busy=%b want 0 0", context_o, busy);
      end
      for (int k = 0; k < 3; k++) begin
         wait_valid(found);
         checks++;
         if (!found || instruction !== exp[k]) begin
            errors++; $display("FAIL stall_ctx0[%0d] got v=%b instr=%h want %h", k, instr_valid, instruction, exp[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_err();
      instr_ready = 1'b1;
      ctx_switch = 1'b1; ctx_sel = 2'd3;
      @(negedge clk);
      ctx_switch = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_sel got err=%b busy=%b want 1 0", err, busy); end
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_sel_pulse got err=%b want 0", err); end
      write(2'd0, 2'd3, 8'hFF);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_ch got err=%b want 1", err); end
      write(2'd3, 2'd0, 8'hEE);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_ctx got err=%b want 1", err); end
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_ctx_pulse got err=%b want 0", err); end
      wr_en = 1'b1; wr_ctx = 2'd0; wr_ch = 2'd3; ctx_switch = 1'b1; ctx_sel = 2'd3;
      @(negedge clk);
      wr_en = 1'b0; ctx_switch = 1'b0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_both got err=%b want 1", err); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0 || context_o !== 2'd0) begin
            errors++; $display("FAIL err_nochange[%0d] got err=%b v=%b busy=%b ctx=%0d want 0 0 0 0", i, err, instr_valid, busy, context_o);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      logic [1:0] c;
      logic [15:0] exp [3] = '{16'h3F00, 16'h7F00, 16'hBF00};
      instr_ready = 1'b0;
      write(2'd0, 2'd2, 8'h77);
      wait_valid(found);
      checks++;
      if (!found || instruction !== 16'hBF77) begin errors++; $display("FAIL rst_pre got instr=%h want bf77", instruction); end
      for (int phase = 0; phase < 2; phase++) begin
         if (phase == 1) begin
            wr_en = 1'b1; wr_ctx = 2'd1; wr_ch = 2'd0; wr_data = 8'h99;
            ctx_switch = 1'b1; ctx_sel = 2'd1;
            @(negedge clk);
            wr_en = 1'b0; ctx_switch = 1'b0;
            @(negedge clk);
         end
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({instruction, instr_valid, context_o, busy, err} !== 21'd0) begin
               errors++;
               $display("FAIL rst_mid[%0d.%0d] got instr=%h v=%b ctx=%0d busy=%b err=%b want all 0", phase, i, instruction, instr_valid, context_o, busy, err);
            end
            @(negedge clk);
         end
      end
      instr_ready = 1'b1;
      for (int j = 0; j < 2; j++) begin
         c = (j == 0) ? 2'd1 : 2'd0;
         ctx_switch = 1'b1; ctx_sel = c;
         @(negedge clk);
         ctx_switch = 1'b0;
         @(negedge clk); @(negedge clk);
         checks++;
         if (context_o !== c) begin errors++; $display("FAIL rst_ctx[%0d] got ctx=%0d want %0d", j, context_o, c); end
         for (int k = 0; k < 3; k++) begin
            wait_valid(found);
            checks++;
            if (!found || instruction !== exp[k]) begin
               errors++; $display("FAIL rst_readback[%0d.%0d] got v=%b instr=%h want %h", j, k, instr_valid, instruction, exp[k]);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_order();
      test_switch();
      test_stall_switch();
      test_err();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
